// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for a 3-stage S1 -> S2 -> S3 pipeline.
//   Keeps a shadow scoreboard of the S2/S3 write destinations. S1 is stalled on a
//   read-after-write hazard. A small RUN/MULTI FSM holds S2 while a long-latency ALU op
//   executes there.
// Build option: define MULTI_BYPASS_EN to turn on operand forwarding.
//   - With forwarding, only S2 matches against a multi-cycle producer stall S1.
//   - Without it, fwd_a/fwd_b are tied to 00 and every S2/S3 match stalls S1.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   s1_valid                 S1 holds a real instruction
//   s1_rs1/_used             source A of the S1 instruction and its read flag
//   s1_rs2/_used             source B of the S1 instruction and its read flag
//   s1_we, s1_wsel           destination write enable and destination register of S1
//   s1_multi                 S1 instruction is a multi-cycle ALU op
//   stall_s1                 hold the PC and the S1 register
//   bubble_s2                load zero controls into the S1/S2 register
//   hold_s2                  S1/S2 register keeps its value
//   bubble_s3                load zero controls into the S2/S3 register
//   fwd_a, fwd_b             operand source: 00 regfile, 01 S2 result, 10 S3 writeback
module pipe_hazard_ctrl #(
  parameter int unsigned MULTI_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s1_valid,
  input  logic [4:0] s1_rs1,
  input  logic       s1_rs1_used,
  input  logic [4:0] s1_rs2,
  input  logic       s1_rs2_used,
  input  logic       s1_we,
  input  logic [4:0] s1_wsel,
  input  logic       s1_multi,
  output logic       stall_s1,
  output logic       bubble_s2,
  output logic       hold_s2,
  output logic       bubble_s3,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
`ifdef MULTI_BYPASS_EN
  localparam logic [FWD_W-1:0] FWD_S2 = 2'b01;
  localparam logic [FWD_W-1:0] FWD_S3 = 2'b10;
`endif

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s2_we_q, s2_we_d;
  logic [REG_W-1:0]   s2_wsel_q, s2_wsel_d;
  logic               s2_multi_q, s2_multi_d;
  logic               s3_we_q, s3_we_d;
  logic [REG_W-1:0]   s3_wsel_q, s3_wsel_d;

  logic a_s2, a_s3, b_s2, b_s3;
  logic raw;
  logic hold;

  // State and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      s2_we_q    <= 1'b0;
      s2_wsel_q  <= '0;
      s2_multi_q <= 1'b0;
      s3_we_q    <= 1'b0;
      s3_wsel_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s2_we_q    <= s2_we_d;
      s2_wsel_q  <= s2_wsel_d;
      s2_multi_q <= s2_multi_d;
      s3_we_q    <= s3_we_d;
      s3_wsel_q  <= s3_wsel_d;
    end
  end

  // Source/destination matches; register 0 is hard-wired and never a hazard.
  always_comb begin
    a_s2 = s1_rs1_used && (s1_rs1 != '0) && s2_we_q && (s2_wsel_q == s1_rs1);
    a_s3 = s1_rs1_used && (s1_rs1 != '0) && s3_we_q && (s3_wsel_q == s1_rs1);
    b_s2 = s1_rs2_used && (s1_rs2 != '0) && s2_we_q && (s2_wsel_q == s1_rs2);
    b_s3 = s1_rs2_used && (s1_rs2 != '0) && s3_we_q && (s3_wsel_q == s1_rs2);
  end

  // Hazard detection and forwarding select.
  always_comb begin
    raw   = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
`ifdef MULTI_BYPASS_EN
    // Only a multi-cycle producer still in S2 has no bypassable result yet.
    raw   = s1_valid && s2_multi_q && (a_s2 || b_s2);
    fwd_a = a_s2 ? FWD_S2 : (a_s3 ? FWD_S3 : FWD_RF);
    fwd_b = b_s2 ? FWD_S2 : (b_s3 ? FWD_S3 : FWD_RF);
`else
    raw   = s1_valid && (a_s2 || a_s3 || b_s2 || b_s3);
`endif
  end

  // Multi-cycle FSM: next state, counter and S2 hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    case (state_q)
      ST_RUN: begin
        hold = s2_multi_q;
        if (s2_multi_q) begin
          // The RUN cycle that spots the op counts as its first cycle in S2.
          state_d = ST_MULTI;
          cnt_d   = CNT_W'(MULTI_LAT - 2);
        end
      end
      ST_MULTI: begin
        hold = (cnt_q != '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Pipeline controls (hold wins over hazard) and scoreboard update.
  always_comb begin
    hold_s2   = hold;
    stall_s1  = hold | raw;
    bubble_s2 = raw & ~hold;
    bubble_s3 = hold;

    s2_we_d    = s2_we_q;
    s2_wsel_d  = s2_wsel_q;
    s2_multi_d = s2_multi_q;
    if (!hold) begin
      if (stall_s1 || !s1_valid) begin
        s2_we_d    = 1'b0;
        s2_wsel_d  = '0;
        s2_multi_d = 1'b0;
      end else begin
        s2_we_d    = s1_we;
        s2_wsel_d  = s1_wsel;
        s2_multi_d = s1_multi;
      end
    end

    s3_we_d   = hold ? 1'b0 : s2_we_q;
    s3_wsel_d = hold ? '0 : s2_wsel_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MULTI_LAT = 4).
// Expected values cover both builds; the MULTI_BYPASS_EN variant is picked at compile time.
module tb_pipe_hazard_ctrl;

`ifdef MULTI_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       s1_valid;
  logic [4:0] s1_rs1;
  logic       s1_rs1_used;
  logic [4:0] s1_rs2;
  logic       s1_rs2_used;
  logic       s1_we;
  logic [4:0] s1_wsel;
  logic       s1_multi;
  logic       stall_s1;
  logic       bubble_s2;
  logic       hold_s2;
  logic       bubble_s3;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  logic [7:0] obs;
  logic [7:0] exp_v;
  int         total;
  int         bad;

  pipe_hazard_ctrl #(.MULTI_LAT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .s1_valid   (s1_valid),
    .s1_rs1     (s1_rs1),
    .s1_rs1_used(s1_rs1_used),
    .s1_rs2     (s1_rs2),
    .s1_rs2_used(s1_rs2_used),
    .s1_we      (s1_we),
    .s1_wsel    (s1_wsel),
    .s1_multi   (s1_multi),
    .stall_s1   (stall_s1),
    .bubble_s2  (bubble_s2),
    .hold_s2    (hold_s2),
    .bubble_s3  (bubble_s3),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  // Observed vector: {stall_s1, bubble_s2, hold_s2, bubble_s3, fwd_a, fwd_b}
  assign obs = {stall_s1, bubble_s2, hold_s2, bubble_s3, fwd_a, fwd_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pick(input logic [7:0] no_byp, input logic [7:0] byp);
    return BYP ? byp : no_byp;
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic we,
                       input logic [4:0] ws, input logic m);
    s1_valid    = v;
    s1_rs1      = r1;
    s1_rs1_used = u1;
    s1_rs2      = r2;
    s1_rs2_used = u2;
    s1_we       = we;
    s1_wsel     = ws;
    s1_multi    = m;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); next_cycle();
    rst = 1'b0; drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0); next_cycle();
    rst = 1'b1; drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    next_cycle(); next_cycle();
    rst = 1'b0;
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_out obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = pick(8'hC0, 8'h04); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_issue obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_raw_s2();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL raw_i0 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    exp_v = pick(8'hC0, 8'h04); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL raw_s2 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = pick(8'hC0, 8'h08); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL raw_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL raw_issue obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_rs2_s3();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0); next_cycle();
    idle();
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rs2_gap obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0);
    exp_v = pick(8'hC0, 8'h02); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rs2_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_no_match();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0); next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0);
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL nm_we0 obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0); next_cycle();
    drive(1'b1, 5'd12, 1'b0, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL nm_unused obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0); next_cycle();
    drive(1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs[7:4] !== exp_v[7:4]) begin bad++; $display("FAIL nm_invalid obs=%b exp=%b", obs[7:4], exp_v[7:4]); end
    next_cycle(); flush();
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0); next_cycle();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL r0_s2 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL r0_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_multi();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1);
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mul_issue obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_v = 8'hB0; @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mul_hold%0d obs=%b exp=%b", i, obs, exp_v); end
      next_cycle();
    end
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mul_leave obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_v = pick(8'hC0, 8'h08); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mul_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_multi_dep();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1); next_cycle();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_v = pick(8'hB0, 8'hB4); @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL dep_hold%0d obs=%b exp=%b", i, obs, exp_v); end
      next_cycle();
    end
    exp_v = pick(8'hC0, 8'hC4); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL dep_s2 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = pick(8'hC0, 8'h08); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL dep_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL dep_issue obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1); next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_v = 8'hB0; @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL b2b_hold1_%0d obs=%b exp=%b", i, obs, exp_v); end
      next_cycle();
    end
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL b2b_handoff obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      exp_v = 8'hB0; @(negedge clk); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL b2b_hold2_%0d obs=%b exp=%b", i, obs, exp_v); end
      next_cycle();
    end
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL b2b_done obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_reset_mid_multi();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1); next_cycle();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); next_cycle();
    rst = 1'b1;
    exp_v = pick(8'hB0, 8'hB4); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rmm_pre obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    rst = 1'b0;
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rmm_after obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = 8'h00; @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rmm_run obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0); next_cycle();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    exp_v = pick(8'hC0, 8'h05); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL byp_s2 obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_v = pick(8'hC0, 8'h08); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL byp_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  task automatic test_fwd_priority();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0); next_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0); next_cycle();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    exp_v = pick(8'hC0, 8'h05); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pri_both obs=%b exp=%b", obs, exp_v); end
    next_cycle();
    exp_v = pick(8'hC0, 8'h0A); @(negedge clk); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pri_s3 obs=%b exp=%b", obs, exp_v); end
    next_cycle(); flush();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_raw_s2();
    test_rs2_s3();
    test_no_match();
    test_r0();
    test_multi();
    test_multi_dep();
    test_back_to_back();
    test_reset_mid_multi();
    test_bypass();
    test_fwd_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
